mac_operand_streamer: RTL and testbench
=======================================

// Module: mac_operand_streamer
// PURPOSE
//  AXI-Stream master that feeds staged_mac's SD_AXIS slave port. Per job it reads weight/activation
//  pairs from two 1-cycle-latency BRAM read ports and emits {weight, activation} beats.
//  It optionally emits a leading bias beat (TUSER=1), asserts TLAST on the final beat and tags every beat with a job TID.
//  It sits between the layer controller (cfg/start/done) and staged_mac.
// PARAMETERS
//  DATA_WIDTH  32  width of weight and of activation; TDATA is 2*DATA_WIDTH
//  ADDR_WIDTH  10  BRAM address width; also the width of the beat count
//  TID_WIDTH   8   AXIS TID width
// PORTS
//  ACLK            in   1              clock
//  ARESETN         in   1              asynchronous active-low reset
//  CFG_START       in   1              1-cycle pulse, starts a job; ignored while BUSY
//  CFG_LEN         in   ADDR_WIDTH     number of data beats N (0 allowed)
//  CFG_W_BASE      in   ADDR_WIDTH     weight BRAM start address
//  CFG_A_BASE      in   ADDR_WIDTH     activation BRAM start address
//  CFG_BIAS_EN     in   1              emit bias beat first
//  CFG_BIAS        in   DATA_WIDTH     bias value (fixed-point, same format as activation)
//  CFG_TID         in   TID_WIDTH      TID for every beat of the job
//  W_ADDR/A_ADDR   out  ADDR_WIDTH     BRAM read addresses
//  W_EN/A_EN       out  1              BRAM read enables (driven identically)
//  W_RDATA/A_RDATA in   DATA_WIDTH     BRAM data, valid the cycle after *_EN
//  MD_AXIS_TVALID  out  1              beat valid
//  MD_AXIS_TREADY  in   1              MAC ready
//  MD_AXIS_TDATA   out  2*DATA_WIDTH   {weight[DW-1:0], activation[DW-1:0]} (weight in upper half)
//  MD_AXIS_TLAST   out  1              final beat of job
//  MD_AXIS_TUSER   out  1              accumulator-init beat (bias beat only)
//  MD_AXIS_TID     out  TID_WIDTH      job tag
//  BUSY            out  1              job in progress
//  DONE            out  1              1-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset: all outputs 0. Skid buffer is empty and the FSM is in IDLE. Assertion mid-job aborts immediately: no TLAST, no DONE.
//  - CFG_* are latched on an accepted START. The inputs may change afterwards without effect.
//  - FSM states:
//    - IDLE: on START go to BIAS if CFG_BIAS_EN, else FETCH if LEN>0, else DONE.
//    - BIAS: push {0, CFG_BIAS} with TUSER=1 into the skid buffer; go to FETCH if LEN>0, else DRAIN.
//    - FETCH: issue read i at W_BASE+i / A_BASE+i, i=0..N-1. Addresses wrap modulo 2^ADDR_WIDTH.
//      After issuing read N-1 go to DRAIN.
//    - DRAIN: wait until the last beat completes its handshake, then go to DONE.
//    - DONE: DONE=1 for one cycle, BUSY=0, return to IDLE.
//  - Read issue: a read is issued only when the skid buffer is guaranteed a free slot one cycle later.
//    The condition is: buffer occupancy + reads in flight < 2.
//    No BRAM data is ever dropped, and no rdata register is needed beyond the buffer.
//  - Beat contents:
//    - Bias beat: TDATA={DATA_WIDTH'0, bias}, TUSER=1. Weight is 0, so the MAC product adds 0.
//    - Data beats: TUSER=0.
//    - TLAST=1 on exactly one beat per job: the last data beat, or the bias beat when N=0.
//  - N=0 with bias disabled: no beats are emitted. BUSY is high for 1 cycle and DONE pulses on the cycle after START.
//  - AXIS rules:
//    - TVALID never depends combinationally on TREADY.
//    - Once TVALID=1, TDATA/TLAST/TUSER/TID hold until the handshake.
//    - All outputs are registered.
//  - Latency: START at cycle 0 -> first TVALID at cycle 2 for a data beat, cycle 1 for a bias beat.
//  - Throughput: with TREADY held high, 1 beat/cycle sustained.
//  - BUSY rises the cycle after START and falls with DONE's falling edge (BUSY=1 during DONE).
//  - A START during BUSY or DONE is ignored. A START in the cycle after DONE is accepted.
// STRUCTURE
//  - mac_pkg holds:
//    - DATA_WIDTH/ACCUM_BITS defaults shared with staged_mac
//    - typedef struct packed {logic [DW-1:0] w, a;} mac_operand_t
//    - typedef enum {IDLE,BIAS,FETCH,DRAIN,DONE} streamer_state_t
//  - Sub-module axis_skid_buffer holds data, last, user and id. It is 2-entry, registered valid/data, and reusable by staged_mac.
//  - Top level contains the FSM, address/beat counters and the in-flight tracking.
// TESTING
//  - N=4, bias off, W_BASE=0x010, A_BASE=0x200, TREADY=1: 4 beats on consecutive cycles.
//    Addresses go 0x010..0x013 and 0x200..0x203. TLAST on beat 3 only. DONE 1 cycle after the last handshake.
//  - N=3, bias on, BIAS=0x00024000, TID=0x5A: 4 beats.
//    Beat0={0x00000000,0x00024000} with TUSER=1. TUSER=0 thereafter. TLAST on beat3. All beats TID=0x5A.
//  - N=10, random TREADY (50%): the TDATA sequence equals the BRAM contents in order.
//    No drop or duplicate, stable TDATA while stalled, exactly one TLAST.
//    The MAC output matches the scoreboard accumulation.
//  - N=0: with bias on -> single beat, TUSER=TLAST=1. With bias off -> no TVALID, DONE at cycle 1.
//  - W_BASE=0x3FE, N=4, ADDR_WIDTH=10: addresses 0x3FE,0x3FF,0x000,0x001.
//  - ARESETN low mid-job with TVALID stalled: all outputs 0 immediately.
//    The next START runs a clean job with a correct TLAST and a single DONE.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC datapath types: operand packing and streamer FSM states.
// Widths here are the defaults staged_mac and its feeders agree on.
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 32;
  localparam int MAC_ACCUM_BITS = 64;

  typedef struct packed {
    logic [MAC_DATA_WIDTH-1:0] w;
    logic [MAC_DATA_WIDTH-1:0] a;
  } mac_operand_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } streamer_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer; head entry drives the master outputs
// straight from flops so TVALID/TDATA never depend on TREADY.
module axis_skid_buffer #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_user,
  input  logic [ID_W-1:0]   i_id,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_tuser,
  output logic [ID_W-1:0]   o_tid,
  output logic [1:0]        o_count
);

  localparam int PW = DATA_W + ID_W + 2;

  logic [PW-1:0] r_p0;
  logic [PW-1:0] r_p1;
  logic          r_v0;
  logic          r_v1;
  logic [PW-1:0] w_in;
  logic          w_pop;

  assign w_in  = {i_data, i_last, i_user, i_id};
  assign w_pop = r_v0 & i_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (w_pop) begin
      if (r_v1) begin
        r_p0 <= r_p1;
        r_v1 <= i_push;
        if (i_push) r_p1 <= w_in;
      end else begin
        r_v0 <= i_push;
        if (i_push) r_p0 <= w_in;
      end
    end else if (i_push) begin
      if (!r_v0) begin
        r_p0 <= w_in;
        r_v0 <= 1'b1;
      end else begin
        r_p1 <= w_in;
        r_v1 <= 1'b1;
      end
    end
  end

  assign o_tvalid = r_v0;
  assign {o_tdata, o_tlast, o_tuser, o_tid} = r_p0;
  assign o_count  = {r_v1, r_v0 & ~r_v1};

endmodule

// File: rtl/mac_operand_streamer.sv
// Streams {weight, activation} beats from two BRAM ports to staged_mac,
// with an optional leading bias beat and a per-job TID.
module mac_operand_streamer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int TID_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    CFG_START,
  input  logic [ADDR_WIDTH-1:0]   CFG_LEN,
  input  logic [ADDR_WIDTH-1:0]   CFG_W_BASE,
  input  logic [ADDR_WIDTH-1:0]   CFG_A_BASE,
  input  logic                    CFG_BIAS_EN,
  input  logic [DATA_WIDTH-1:0]   CFG_BIAS,
  input  logic [TID_WIDTH-1:0]    CFG_TID,
  output logic [ADDR_WIDTH-1:0]   W_ADDR,
  output logic [ADDR_WIDTH-1:0]   A_ADDR,
  output logic                    W_EN,
  output logic                    A_EN,
  input  logic [DATA_WIDTH-1:0]   W_RDATA,
  input  logic [DATA_WIDTH-1:0]   A_RDATA,
  output logic                    MD_AXIS_TVALID,
  input  logic                    MD_AXIS_TREADY,
  output logic [2*DATA_WIDTH-1:0] MD_AXIS_TDATA,
  output logic                    MD_AXIS_TLAST,
  output logic                    MD_AXIS_TUSER,
  output logic [TID_WIDTH-1:0]    MD_AXIS_TID,
  output logic                    BUSY,
  output logic                    DONE
);

  streamer_state_t r_state;
  streamer_state_t w_nxt;

  logic [ADDR_WIDTH-1:0] r_w_ptr;
  logic [ADDR_WIDTH-1:0] r_a_ptr;
  logic [ADDR_WIDTH-1:0] r_left;
  logic [TID_WIDTH-1:0]  r_tid;
  logic                  r_len_zero;
  logic                  r_rd_q;
  logic                  r_rd_last;
  logic                  r_busy;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0]   w_left;
  logic [ADDR_WIDTH-1:0]   w_raddr_w;
  logic [ADDR_WIDTH-1:0]   w_raddr_a;
  logic [1:0]              w_count;
  logic [2:0]              w_occ;
  logic                    w_idle;
  logic                    w_start;
  logic                    w_bias_push;
  logic                    w_fetching;
  logic                    w_pop;
  logic                    w_can;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_push;
  logic [2*DATA_WIDTH-1:0] w_data;
  logic                    w_last;
  logic [TID_WIDTH-1:0]    w_id;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start     = CFG_START & w_idle;
  assign w_bias_push = w_start & CFG_BIAS_EN;
  assign w_fetching  = (r_state == ST_BIAS) | (r_state == ST_FETCH);
  assign w_pop       = MD_AXIS_TVALID & MD_AXIS_TREADY;

  // A read may issue only if its data is sure of a slot next cycle.
  assign w_occ = {1'b0, w_count} + {2'b00, r_rd_q} + {2'b00, w_bias_push};
  assign w_can = w_occ < (3'd2 + {2'b00, w_pop});

  assign w_left       = w_idle ? CFG_LEN : r_left;
  assign w_raddr_w    = w_idle ? CFG_W_BASE : r_w_ptr;
  assign w_raddr_a    = w_idle ? CFG_A_BASE : r_a_ptr;
  assign w_issue      = (w_start | w_fetching) & (w_left != '0) & w_can;
  assign w_issue_last = w_issue & (w_left == ADDR_WIDTH'(1));

  assign W_EN   = w_issue;
  assign A_EN   = w_issue;
  assign W_ADDR = w_issue ? w_raddr_w : '0;
  assign A_ADDR = w_issue ? w_raddr_a : '0;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (CFG_START) begin
          if (CFG_BIAS_EN)          w_nxt = ST_BIAS;
          else if (CFG_LEN != '0)   w_nxt = ST_FETCH;
          else                      w_nxt = ST_DONE;
        end
      end
      ST_BIAS: begin
        if (r_len_zero)
          w_nxt = w_pop ? ST_DONE : ST_DRAIN;
        else if ((r_left == '0) | w_issue_last)
          w_nxt = ST_DRAIN;
        else
          w_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if ((r_left == '0) | w_issue_last) w_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop & MD_AXIS_TLAST) w_nxt = ST_DONE;
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= ST_IDLE;
      r_w_ptr    <= '0;
      r_a_ptr    <= '0;
      r_left     <= '0;
      r_tid      <= '0;
      r_len_zero <= 1'b0;
      r_rd_q     <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_rd_q    <= w_issue;
      r_rd_last <= w_issue_last;
      r_busy    <= (w_nxt != ST_IDLE);
      r_done    <= (w_nxt == ST_DONE);
      if (w_start) begin
        r_tid      <= CFG_TID;
        r_len_zero <= (CFG_LEN == '0);
      end
      if (w_issue) begin
        r_w_ptr <= w_raddr_w + ADDR_WIDTH'(1);
        r_a_ptr <= w_raddr_a + ADDR_WIDTH'(1);
        r_left  <= w_left - ADDR_WIDTH'(1);
      end else if (w_start) begin
        r_left  <= CFG_LEN;
      end
    end
  end

  // Bias beat enters on the START edge; BRAM data lands one cycle after issue.
  assign w_push = w_bias_push | r_rd_q;
  assign w_data = w_bias_push ? {{DATA_WIDTH{1'b0}}, CFG_BIAS}
                              : {W_RDATA, A_RDATA};
  assign w_last = w_bias_push ? (CFG_LEN == '0) : r_rd_last;
  assign w_id   = w_bias_push ? CFG_TID : r_tid;

  axis_skid_buffer #(
    .DATA_W (2*DATA_WIDTH),
    .ID_W   (TID_WIDTH)
  ) u_skid (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .i_push   (w_push),
    .i_data   (w_data),
    .i_last   (w_last),
    .i_user   (w_bias_push),
    .i_id     (w_id),
    .i_tready (MD_AXIS_TREADY),
    .o_tvalid (MD_AXIS_TVALID),
    .o_tdata  (MD_AXIS_TDATA),
    .o_tlast  (MD_AXIS_TLAST),
    .o_tuser  (MD_AXIS_TUSER),
    .o_tid    (MD_AXIS_TID),
    .o_count  (w_count)
  );

  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Directed bench for mac_operand_streamer with BRAM models and a
// beat/address scoreboard filled at job start and drained on handshakes.
module tb_mac_operand_streamer;
  import mac_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        CFG_START = 1'b0;
  logic [9:0]  CFG_LEN = '0;
  logic [9:0]  CFG_W_BASE = '0;
  logic [9:0]  CFG_A_BASE = '0;
  logic        CFG_BIAS_EN = 1'b0;
  logic [31:0] CFG_BIAS = '0;
  logic [7:0]  CFG_TID = '0;
  logic [9:0]  W_ADDR, A_ADDR;
  logic        W_EN, A_EN;
  logic [31:0] W_RDATA = '0;
  logic [31:0] A_RDATA = '0;
  logic        MD_AXIS_TVALID;
  logic        MD_AXIS_TREADY = 1'b0;
  logic [63:0] MD_AXIS_TDATA;
  logic        MD_AXIS_TLAST, MD_AXIS_TUSER;
  logic [7:0]  MD_AXIS_TID;
  logic        BUSY, DONE;

  mac_operand_streamer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CFG_START(CFG_START), .CFG_LEN(CFG_LEN),
    .CFG_W_BASE(CFG_W_BASE), .CFG_A_BASE(CFG_A_BASE),
    .CFG_BIAS_EN(CFG_BIAS_EN), .CFG_BIAS(CFG_BIAS), .CFG_TID(CFG_TID),
    .W_ADDR(W_ADDR), .A_ADDR(A_ADDR), .W_EN(W_EN), .A_EN(A_EN),
    .W_RDATA(W_RDATA), .A_RDATA(A_RDATA),
    .MD_AXIS_TVALID(MD_AXIS_TVALID), .MD_AXIS_TREADY(MD_AXIS_TREADY),
    .MD_AXIS_TDATA(MD_AXIS_TDATA), .MD_AXIS_TLAST(MD_AXIS_TLAST),
    .MD_AXIS_TUSER(MD_AXIS_TUSER), .MD_AXIS_TID(MD_AXIS_TID),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] w_mem [1024];
  logic [31:0] a_mem [1024];

  always @(posedge ACLK) begin
    if (W_EN) W_RDATA <= w_mem[W_ADDR];
    if (A_EN) A_RDATA <= a_mem[A_ADDR];
  end

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        u;
    logic [7:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic [9:0]  wq[$];
  logic [9:0]  aq[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  int          t0, first_valid, last_hs, done_cyc;
  int          ndone, nbeats, nlast;
  bit          done_seen, held_v;
  bit          rnd_ready = 1'b0;
  bit          fix_ready = 1'b1;
  logic [73:0] held;
  logic [63:0] acc_obs, acc_exp;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    beat_t e;
    if (W_EN || A_EN) begin
      chk("en_pair", {78'd0, W_EN, A_EN}, 80'd3);
      chk("w_addr", W_ADDR, wq.size() > 0 ? wq.pop_front() : 80'hDEAD);
      chk("a_addr", A_ADDR, aq.size() > 0 ? aq.pop_front() : 80'hDEAD);
    end
    if (held_v && !MD_AXIS_TVALID) chk("valid_held", MD_AXIS_TVALID, 1);
    if (MD_AXIS_TVALID) begin
      if (first_valid < 0) first_valid = cyc_no;
      if (held_v)
        chk("stall_stable", {MD_AXIS_TDATA, MD_AXIS_TLAST,
                             MD_AXIS_TUSER, MD_AXIS_TID}, held);
      if (MD_AXIS_TREADY) begin
        held_v = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tdata", MD_AXIS_TDATA, e.d);
          chk("tlast", MD_AXIS_TLAST, e.l);
          chk("tuser", MD_AXIS_TUSER, e.u);
          chk("tid", MD_AXIS_TID, e.id);
        end else begin
          chk("extra_beat", 1, 0);
        end
        nbeats++;
        if (MD_AXIS_TLAST) begin
          nlast++;
          last_hs = cyc_no;
        end
        acc_obs = MD_AXIS_TUSER ? {32'd0, MD_AXIS_TDATA[31:0]}
                : acc_obs + {32'd0, MD_AXIS_TDATA[63:32]} *
                            {32'd0, MD_AXIS_TDATA[31:0]};
      end else begin
        held_v = 1'b1;
        held = {MD_AXIS_TDATA, MD_AXIS_TLAST, MD_AXIS_TUSER, MD_AXIS_TID};
      end
    end
    if (DONE) begin
      ndone++;
      done_seen = 1'b1;
      done_cyc = cyc_no;
      chk("busy_in_done", BUSY, 1);
    end
  endtask

  task automatic cyc();
    @(negedge ACLK);
    mon();
    @(posedge ACLK);
    cyc_no++;
    #1;
    MD_AXIS_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
  endtask

  task automatic start_job(input int len, input logic [9:0] wb,
                           input logic [9:0] ab, input logic ben,
                           input logic [31:0] bias, input logic [7:0] tid,
                           input bit poke);
    beat_t        e;
    mac_operand_t op;
    logic [9:0]   wa, aa;
    first_valid = -1; last_hs = -1; done_cyc = -1;
    ndone = 0; nbeats = 0; nlast = 0;
    done_seen = 1'b0; held_v = 1'b0;
    acc_obs = '0; acc_exp = '0;
    if (ben) begin
      op.w = '0; op.a = bias;
      e.d = op; e.l = (len == 0); e.u = 1'b1; e.id = tid;
      exp_q.push_back(e);
      acc_exp = {32'd0, bias};
    end
    for (int i = 0; i < len; i++) begin
      wa = wb + 10'(i);
      aa = ab + 10'(i);
      wq.push_back(wa);
      aq.push_back(aa);
      op.w = w_mem[wa]; op.a = a_mem[aa];
      e.d = op; e.l = (i == len - 1); e.u = 1'b0; e.id = tid;
      exp_q.push_back(e);
      acc_exp = acc_exp + {32'd0, op.w} * {32'd0, op.a};
    end
    CFG_LEN = 10'(len); CFG_W_BASE = wb; CFG_A_BASE = ab;
    CFG_BIAS_EN = ben; CFG_BIAS = bias; CFG_TID = tid;
    CFG_START = 1'b1;
    t0 = cyc_no;
    cyc();
    CFG_START = 1'b0;
    chk("busy_rise", BUSY, 1);
    if (poke) begin
      CFG_LEN = 10'($urandom); CFG_W_BASE = 10'($urandom);
      CFG_A_BASE = 10'($urandom); CFG_BIAS_EN = 1'b1;
      CFG_BIAS = $urandom; CFG_TID = 8'hEE;
      CFG_START = 1'b1;
      cyc();
      CFG_START = 1'b0;
    end
  endtask

  task automatic run_job(input int len, input logic [9:0] wb,
                         input logic [9:0] ab, input logic ben,
                         input logic [31:0] bias, input logic [7:0] tid,
                         input int exp_first, input int exp_done,
                         input bit poke);
    start_job(len, wb, ab, ben, bias, tid, poke);
    for (int n = 0; n < 400 && !done_seen; n++) cyc();
    chk("done_seen", done_seen, 1);
    if (nbeats > 0) chk("done_after_last", done_cyc - last_hs, 1);
    if (exp_done > 0) chk("done_cycle", done_cyc - t0, exp_done);
    chk("first_valid", first_valid < 0 ? 99 : first_valid - t0, exp_first);
    chk("tlast_count", nlast, (len > 0 || ben) ? 1 : 0);
    chk("beat_count", nbeats, len + int'(ben));
    cyc();
    cyc();
    chk("single_done", ndone, 1);
    chk("busy_fall", BUSY, 0);
    chk("sb_drained", exp_q.size(), 0);
    chk("rd_drained", wq.size() + aq.size(), 0);
    chk("mac_acc", acc_obs, acc_exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      w_mem[i] = $urandom;
      a_mem[i] = $urandom;
    end
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_tvalid", MD_AXIS_TVALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_en", {W_EN, A_EN}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    MD_AXIS_TREADY = 1'b1;

    run_job(4, 10'h010, 10'h200, 1'b0, 32'h0, 8'h11, 2, 6, 1'b1);
    run_job(3, 10'h020, 10'h220, 1'b1, 32'h00024000, 8'h5A, 1, 5, 1'b0);
    rnd_ready = 1'b1;
    run_job(10, 10'h040, 10'h240, 1'b0, 32'h0, 8'h77, 2, -1, 1'b0);
    rnd_ready = 1'b0;
    run_job(0, 10'h000, 10'h000, 1'b1, 32'h00001234, 8'h21, 1, 2, 1'b0);
    run_job(0, 10'h000, 10'h000, 1'b0, 32'h0, 8'h22, 99, 1, 1'b0);
    run_job(4, 10'h3FE, 10'h3FF, 1'b0, 32'h0, 8'h33, 2, 6, 1'b0);

    fix_ready = 1'b0;
    MD_AXIS_TREADY = 1'b0;
    start_job(8, 10'h100, 10'h180, 1'b0, 32'h0, 8'h44, 1'b0);
    repeat (6) cyc();
    chk("stalled_valid", MD_AXIS_TVALID, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("abort_tvalid", MD_AXIS_TVALID, 0);
    chk("abort_tdata", MD_AXIS_TDATA, 0);
    chk("abort_flags", {MD_AXIS_TLAST, MD_AXIS_TUSER}, 0);
    chk("abort_tid", MD_AXIS_TID, 0);
    chk("abort_busy_done", {BUSY, DONE}, 0);
    chk("abort_rd", {W_EN, A_EN, W_ADDR, A_ADDR}, 0);
    exp_q.delete();
    wq.delete();
    aq.delete();
    held_v = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    cyc_no++;
    #1;
    fix_ready = 1'b1;
    MD_AXIS_TREADY = 1'b1;
    run_job(5, 10'h300, 10'h050, 1'b0, 32'h0, 8'h55, 2, 7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
